// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer sharing the single-port data memory between the
// CPU MEM stage and the SAD window-fetch engine. One access every two cycles, range-checked.
module dmem_arbiter #(
    parameter int unsigned CPU_PRIORITY = 0,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_aluCode,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        acc_req,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    input  logic        acc_we,
    input  logic [4:0]  acc_aluCode,
    output logic        acc_ack,
    output logic [31:0] acc_rdata,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_WriteData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic [4:0]  mem_aluCode,
    input  logic [31:0] mem_ReadData,
    output logic        addr_err
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [3:0] MaxWaitW = 4'(MAX_WAIT);

    state_e      state_q;
    logic        last_acc_q;
    logic [3:0]  wait_cnt_q;
    logic        grant_acc_q;
    logic        we_q;
    logic        oor_q;
    logic        cpu_ack_q;
    logic        acc_ack_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] acc_rdata_q;
    logic        addr_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic [4:0]  mem_alu_q;

    logic        cpu_elig;
    logic        acc_elig;
    logic        pick_acc;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [4:0]  sel_alu;
    logic        sel_oor;
    logic [31:0] busy_rdata;

    always_comb begin
        cpu_elig = cpu_req & ~cpu_ack_q;
        acc_elig = acc_req & ~acc_ack_q;
        pick_acc = 1'b0;
        if (acc_elig && !cpu_elig) begin
            pick_acc = 1'b1;
        end else if (acc_elig && cpu_elig) begin
            if (CPU_PRIORITY == 0) pick_acc = ~last_acc_q;
            else                   pick_acc = (wait_cnt_q == MaxWaitW);
        end
        sel_addr  = pick_acc ? acc_addr    : cpu_addr;
        sel_wdata = pick_acc ? acc_wdata   : cpu_wdata;
        sel_we    = pick_acc ? acc_we      : cpu_we;
        sel_alu   = pick_acc ? acc_aluCode : cpu_aluCode;
        sel_oor   = |sel_addr[31:14];
        // Stores and out-of-range accesses return zero.
        busy_rdata = (we_q || oor_q) ? 32'h0 : mem_ReadData;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            last_acc_q  <= 1'b1;
            wait_cnt_q  <= 4'd0;
            grant_acc_q <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            acc_ack_q   <= 1'b0;
            cpu_rdata_q <= 32'h0;
            acc_rdata_q <= 32'h0;
            addr_err_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_alu_q   <= 5'd0;
        end else begin
            cpu_ack_q <= 1'b0;
            acc_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cpu_elig || acc_elig) begin
                        state_q     <= StBusy;
                        grant_acc_q <= pick_acc;
                        last_acc_q  <= pick_acc;
                        we_q        <= sel_we;
                        oor_q       <= sel_oor;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_alu_q   <= sel_alu;
                        mem_we_q    <= sel_we & ~sel_oor;
                        mem_re_q    <= ~sel_we & ~sel_oor;
                        if (pick_acc) begin
                            wait_cnt_q <= 4'd0;
                        end else if (acc_elig && wait_cnt_q != 4'd15) begin
                            wait_cnt_q <= wait_cnt_q + 4'd1;
                        end
                    end
                end
                StBusy: begin
                    state_q     <= StIdle;
                    mem_addr_q  <= 32'h0;
                    mem_wdata_q <= 32'h0;
                    mem_we_q    <= 1'b0;
                    mem_re_q    <= 1'b0;
                    mem_alu_q   <= 5'd0;
                    if (oor_q) addr_err_q <= 1'b1;
                    if (grant_acc_q) begin
                        acc_ack_q   <= 1'b1;
                        acc_rdata_q <= busy_rdata;
                    end else begin
                        cpu_ack_q   <= 1'b1;
                        cpu_rdata_q <= busy_rdata;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_ack       = cpu_ack_q;
    assign acc_ack       = acc_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign acc_rdata     = acc_rdata_q;
    assign cpu_stall     = cpu_req & ~cpu_ack_q;
    assign addr_err      = addr_err_q;
    assign mem_Address   = mem_addr_q;
    assign mem_WriteData = mem_wdata_q;
    assign mem_MemWrite  = mem_we_q;
    assign mem_MemRead   = mem_re_q;
    assign mem_aluCode   = mem_alu_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the pipeline MEM stage (CPU port) and the SAD window-fetch engine (ACC port). It grants one access at a time, drives the memory control and data signals from the winning request, registers the returned read data, and stalls the pipeline while a CPU access is pending. Range checking is built in: an access outside the 4096-word memory never reaches it.

## Interface
- `CPU_PRIORITY`, default 0: 0 selects round-robin; 1 selects fixed CPU priority with an ACC starvation limit.
- `MAX_WAIT`, default 4: ACC lost-arbitration count that forces an ACC grant when `CPU_PRIORITY`=1 (range 1..15).
- `clk` in 1: single clock. All state updates on posedge. The memory writes on negedge.
- `Reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request. Held until `cpu_ack`.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_aluCode` in 5: access-size code (sw/sh/sb/lw/lh/lb), passed to memory unchanged.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: load data. Valid in the `cpu_ack` cycle and held until the next `cpu_ack`.
- `cpu_stall` out 1: equals `cpu_req & ~cpu_ack` (combinational).
- `acc_req`, `acc_addr`, `acc_wdata`, `acc_we`, `acc_aluCode`, `acc_ack`, `acc_rdata`: same meanings as the CPU port, for the SAD engine.
- `mem_Address` out 32: memory byte address.
- `mem_WriteData` out 32: memory write data.
- `mem_MemWrite` out 1: memory write enable.
- `mem_MemRead` out 1: memory read enable.
- `mem_aluCode` out 5: access-size code to memory.
- `mem_ReadData` in 32: combinational read data from memory.
- `addr_err` out 1: sticky. Set when an access address has any of bits [31:14] nonzero. Cleared only by `Reset`.

## Operation
- The state machine has two states, IDLE and BUSY.
- **IDLE:**
  - All `mem_*` outputs are 0.
  - Eligible requests are `cpu_req & ~cpu_ack` and `acc_req & ~acc_ack`. A request raised in the same cycle as its own ack is ignored.
  - If any request is eligible, select a winner. Latch its addr, wdata, we and aluCode plus the grant ID, then go to BUSY.
- **BUSY:**
  - `mem_Address`, `mem_WriteData` and `mem_aluCode` come from the latched fields.
  - `mem_MemWrite` = latched we. `mem_MemRead` = ~latched we.
  - On the closing posedge, capture `mem_ReadData` into the winner's rdata register. A store captures 0.
  - Pulse the winner's ack in the next cycle and return to IDLE.
- **Round-robin (`CPU_PRIORITY`=0):**
  - A single requester always wins.
  - On contention, the port not equal to `last_grant` wins.
  - `last_grant` updates on every grant.
- **Priority (`CPU_PRIORITY`=1):**
  - On contention the CPU wins and `wait_cnt` increments.
  - When `wait_cnt` == `MAX_WAIT`, ACC wins the next contention.
  - `wait_cnt` clears on any ACC grant and saturates at 15.
- **Address error:**
  - A latched address with bits [31:14] ≠ 0 forces `mem_MemWrite`=`mem_MemRead`=0 during BUSY.
  - Returned rdata is 0x00000000.
  - `addr_err` sets on the closing posedge.
  - The ack is still delivered.
- **Arithmetic:** only the 4-bit saturating `wait_cnt`. Addresses and data pass through unmodified.

## Timing
- **Uncontended latency:** request seen in IDLE cycle N; BUSY in N+1 (store lands at negedge of N+1); ack and rdata in N+2.
- **Throughput:** at most one access per 2 cycles. The other port may be granted in the ack cycle, N+2, since IDLE and the ack coincide.
- **Requester hold rule:** req and fields must stay stable from assertion through the ack cycle. The arbiter samples them only in IDLE.
- **Reset values:**
  - State IDLE. `last_grant`=ACC, so the CPU wins the first contention. `wait_cnt`=0.
  - Both acks 0, both rdata 0x00000000, `addr_err` 0, all `mem_*` 0.
- **Reset asserted during BUSY:** the store at that cycle's negedge still completes. No ack is issued, rdata is cleared, and the state returns to IDLE.
- **Simultaneous requests with `cpu_ack` high:** only ACC is eligible, so ACC is granted.

## Test plan
- **CPU load:** CPU load from 0x00000010 with memory word 4 = 0xDEADBEEF, no ACC traffic -> `mem_MemRead`=1 in cycle 1, `cpu_ack`=1 and `cpu_rdata`=0xDEADBEEF in cycle 2, `cpu_stall`=1 in cycles 0-1.
- **CPU store then ACC load:** CPU store of 0x12345678 to 0x20, then ACC load from 0x20 -> `acc_rdata`=0x12345678 in the `acc_ack` cycle; `mem_aluCode` follows each requester.
- **Round-robin contention:** both ports request continuously, 4 accesses each, `CPU_PRIORITY`=0 -> grant order CPU, ACC, CPU, ACC, ...; acks 2 cycles apart, alternating ports.
- **Starvation limit:** `CPU_PRIORITY`=1, `MAX_WAIT`=3, both requesting continuously -> grants CPU, CPU, CPU, ACC, then repeat; `wait_cnt` returns to 0 after each ACC grant.
- **Out-of-range access:** ACC store to 0x00010000 -> `mem_MemWrite` stays 0, `acc_ack` after 2 cycles, `acc_rdata`=0, `addr_err`=1 and sticky until `Reset`.
- **Reset during BUSY:** `Reset` pulsed during a BUSY cycle for a CPU store of 0xA5A5A5A5 -> the word is written, no `cpu_ack`, all outputs at reset values the following cycle.
